// File: rtl/spi_master_regs.sv
// Register-mapped SPI master behind a bus2ip/ip2bus register slave.
// CTRL/STATUS/TXDATA/RXDATA feed a single-slave, MSB-first shift engine with CPOL/CPHA and a clock divider.
module spi_master_regs #(
  parameter int         DATA_WIDTH   = 8,
  parameter logic [7:0] CLKDIV_RESET = 8'd4
) (
  input  logic         bus2ip_clk,
  input  logic         bus2ip_reset,
  input  logic [31:0]  bus2ip_data,
  input  logic [3:0]   bus2ip_wrce,
  input  logic [3:0]   bus2ip_rdce,
  output logic [127:0] ip2bus_data,
  output logic         ip2bus_wrack,
  output logic         ip2bus_rdack,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss_n,
  output logic         irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;
  localparam logic [6:0] LAST_EDGE = 7'(2 * DATA_WIDTH - 1);

  // Register file state
  logic                  ctrl_en_q, ctrl_en_d;
  logic                  ctrl_cpol_q, ctrl_cpol_d;
  logic                  ctrl_cpha_q, ctrl_cpha_d;
  logic                  ctrl_ie_q, ctrl_ie_d;
  logic [7:0]            ctrl_div_q, ctrl_div_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  tx_drop_q, tx_drop_d;
  logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;

  // Bus handshake state
  logic                  wr_seen_q, wr_seen_d;
  logic                  rd_seen_q, rd_seen_d;
  logic                  wrack_q, wrack_d;
  logic                  rdack_q, rdack_d;

  // Shift engine state
  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [6:0]            edge_q, edge_d;
  logic                  tog_q, tog_d;
  logic                  lat_cpol_q, lat_cpol_d;
  logic                  lat_cpha_q, lat_cpha_d;
  logic [7:0]            lat_div_q, lat_div_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  mosi_q, mosi_d;

  // Decoded strobes
  logic                  wr_active, wr_pulse, wr_onehot, wr_ok;
  logic                  rd_active, rd_pulse;
  logic                  we_ctrl, we_status, we_tx;
  logic                  busy, tx_accept, tx_reject, xfer_done, sample_edge;
  logic [DATA_WIDTH-1:0] wr_frame, rx_shifted;
  logic [31:0]           ctrl_word, status_word, tx_word, rx_word;
  logic                  unused_bits;

  assign unused_bits = ^bus2ip_data;

  always_comb begin
    wr_active = |bus2ip_wrce;
    wr_pulse  = wr_active & ~wr_seen_q;
    wr_onehot = (bus2ip_wrce & (bus2ip_wrce - 4'd1)) == 4'd0;
    wr_ok     = wr_pulse & wr_onehot;
    rd_active = |bus2ip_rdce;
    rd_pulse  = rd_active & ~rd_seen_q;
    we_ctrl   = wr_ok & bus2ip_wrce[0];
    we_status = wr_ok & bus2ip_wrce[1];
    we_tx     = wr_ok & bus2ip_wrce[2];
    busy      = state_q != ST_IDLE;
    tx_accept = we_tx & ctrl_en_q & ~busy;
    tx_reject = we_tx & ~tx_accept;
    wr_frame  = bus2ip_data[DATA_WIDTH-1:0];
  end

  // The seen flags rise with the ack and drop only once the strobe returns to zero.
  always_comb begin
    wrack_d   = wr_pulse;
    rdack_d   = rd_pulse;
    wr_seen_d = wr_active;
    rd_seen_d = rd_active;
  end

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_cpol_d = ctrl_cpol_q;
    ctrl_cpha_d = ctrl_cpha_q;
    ctrl_ie_d   = ctrl_ie_q;
    ctrl_div_d  = ctrl_div_q;
    txdata_d    = txdata_q;
    if (we_ctrl) begin
      ctrl_en_d   = bus2ip_data[0];
      ctrl_cpol_d = bus2ip_data[1];
      ctrl_cpha_d = bus2ip_data[2];
      ctrl_ie_d   = bus2ip_data[3];
      ctrl_div_d  = bus2ip_data[15:8];
    end
    if (tx_accept) begin
      txdata_d = wr_frame;
    end
  end

  // Completion is applied after the W1C so a coincident clear of rx_valid loses.
  always_comb begin
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_drop_d  = tx_drop_q;
    rxdata_d   = rxdata_q;
    if (we_status) begin
      if (bus2ip_data[1]) rx_valid_d = 1'b0;
      if (bus2ip_data[2]) overrun_d  = 1'b0;
      if (bus2ip_data[3]) tx_drop_d  = 1'b0;
    end
    if (tx_reject) begin
      tx_drop_d = 1'b1;
    end
    if (xfer_done) begin
      rxdata_d   = rx_shift_q;
      overrun_d  = overrun_d | rx_valid_q;
      rx_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tog_d      = tog_q;
    lat_cpol_d = lat_cpol_q;
    lat_cpha_d = lat_cpha_q;
    lat_div_d  = lat_div_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    mosi_d     = mosi_q;
    xfer_done  = 1'b0;
    rx_shifted    = rx_shift_q << 1;
    rx_shifted[0] = spi_miso;
    // Even edge_q means the upcoming toggle is a leading edge.
    sample_edge = ~edge_q[0] ^ lat_cpha_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_accept) begin
          state_d    = ST_LEAD;
          cnt_d      = ctrl_div_q;
          edge_d     = 7'd0;
          tog_d      = 1'b0;
          lat_cpol_d = ctrl_cpol_q;
          lat_cpha_d = ctrl_cpha_q;
          lat_div_d  = ctrl_div_q;
          rx_shift_d = '0;
          if (ctrl_cpha_q) begin
            tx_shift_d = wr_frame;
          end else begin
            mosi_d     = wr_frame[DATA_WIDTH-1];
            tx_shift_d = wr_frame << 1;
          end
        end
      end
      ST_LEAD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SHIFT;
          cnt_d   = lat_div_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = lat_div_q;
          tog_d  = ~tog_q;
          edge_d = edge_q + 7'd1;
          if (sample_edge) begin
            rx_shift_d = rx_shifted;
          end else begin
            mosi_d     = tx_shift_q[DATA_WIDTH-1];
            tx_shift_d = tx_shift_q << 1;
          end
          if (edge_q == LAST_EDGE) begin
            state_d = ST_TRAIL;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_TRAIL: begin
        if (cnt_q == 8'd0) begin
          state_d   = ST_IDLE;
          mosi_d    = 1'b0;
          xfer_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_reset) begin
      ctrl_en_q   <= 1'b0;
      ctrl_cpol_q <= 1'b0;
      ctrl_cpha_q <= 1'b0;
      ctrl_ie_q   <= 1'b0;
      ctrl_div_q  <= CLKDIV_RESET;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_drop_q   <= 1'b0;
      txdata_q    <= '0;
      rxdata_q    <= '0;
      wr_seen_q   <= 1'b0;
      rd_seen_q   <= 1'b0;
      wrack_q     <= 1'b0;
      rdack_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      edge_q      <= 7'd0;
      tog_q       <= 1'b0;
      lat_cpol_q  <= 1'b0;
      lat_cpha_q  <= 1'b0;
      lat_div_q   <= 8'd0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      mosi_q      <= 1'b0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      ctrl_cpol_q <= ctrl_cpol_d;
      ctrl_cpha_q <= ctrl_cpha_d;
      ctrl_ie_q   <= ctrl_ie_d;
      ctrl_div_q  <= ctrl_div_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_drop_q   <= tx_drop_d;
      txdata_q    <= txdata_d;
      rxdata_q    <= rxdata_d;
      wr_seen_q   <= wr_seen_d;
      rd_seen_q   <= rd_seen_d;
      wrack_q     <= wrack_d;
      rdack_q     <= rdack_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      tog_q       <= tog_d;
      lat_cpol_q  <= lat_cpol_d;
      lat_cpha_q  <= lat_cpha_d;
      lat_div_q   <= lat_div_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      mosi_q      <= mosi_d;
    end
  end

  always_comb begin
    ctrl_word   = 32'h0;
    status_word = 32'h0;
    tx_word     = 32'h0;
    rx_word     = 32'h0;
    ctrl_word[0]     = ctrl_en_q;
    ctrl_word[1]     = ctrl_cpol_q;
    ctrl_word[2]     = ctrl_cpha_q;
    ctrl_word[3]     = ctrl_ie_q;
    ctrl_word[15:8]  = ctrl_div_q;
    status_word[0]   = busy;
    status_word[1]   = rx_valid_q;
    status_word[2]   = overrun_q;
    status_word[3]   = tx_drop_q;
    tx_word[DATA_WIDTH-1:0] = txdata_q;
    rx_word[DATA_WIDTH-1:0] = rxdata_q;
  end

  // Idle sclk follows the live CPOL; during a transfer it follows the latched copy.
  assign ip2bus_data  = {rx_word, tx_word, status_word, ctrl_word};
  assign ip2bus_wrack = wrack_q;
  assign ip2bus_rdack = rdack_q;
  assign spi_ss_n     = ~busy;
  assign spi_sclk     = busy ? (lat_cpol_q ^ tog_q) : ctrl_cpol_q;
  assign spi_mosi     = mosi_q;
  assign irq          = rx_valid_q & ctrl_ie_q;

endmodule

// File: doc/spi_master_regs.md
# spi_master_regs

Register-mapped SPI master that sits directly downstream of the AXI-Lite address/data adapter and consumes its `bus2ip_*` strobes. It returns the `ip2bus_*` read data and acknowledges. It holds four 32-bit registers (CTRL, STATUS, TXDATA, RXDATA) and drives a single-slave, MSB-first SPI shift engine with selectable CPOL/CPHA and a programmable clock divider.

## Interface
- `DATA_WIDTH`, default 8: SPI frame length in bits, legal range 1..32.
- `CLKDIV_RESET`, default 8'd4: reset value of CTRL.clkdiv.

Ports (clock and reset first):
- `bus2ip_clk`  in  1: single clock domain for the whole block.
- `bus2ip_reset`  in  1: synchronous, active-high reset.
- `bus2ip_data`  in  32: write data.
- `bus2ip_wrce`  in  4: one-hot write select; bit n selects register n.
- `bus2ip_rdce`  in  4: one-hot read select.
- `ip2bus_data`  out  128: all four registers in parallel, packed as {RXDATA, TXDATA, STATUS, CTRL}, with CTRL in [31:0].
- `ip2bus_wrack`  out  1: write acknowledge pulse.
- `ip2bus_rdack`  out  1: read acknowledge pulse.
- `spi_sclk`  out  1: SPI clock.
- `spi_mosi`  out  1: master out.
- `spi_miso`  in  1: master in. Sampled directly; the board provides synchronisation.
- `spi_ss_n`  out  1: active-low slave select.
- `irq`  out  1: equals STATUS.rx_valid & CTRL.ie (combinational from registers).

## Operation
Register map:
- **CTRL (reg0, R/W):**
  - [0] enable, [1] cpol, [2] cpha, [3] ie, [15:8] clkdiv.
  - All other bits read 0.
- **STATUS (reg1):**
  - [0] busy: read-only.
  - [1] rx_valid: write-1-to-clear.
  - [2] overrun: write-1-to-clear.
  - [3] tx_drop: write-1-to-clear.
  - Writing 0 to a bit has no effect on it.
- **TXDATA (reg2, R/W):**
  - [DATA_WIDTH-1:0] holds the last accepted frame.
  - A write with enable=1 and busy=0 stores the data and starts a transfer.
  - A write while busy=1, or with enable=0, is acked. It leaves TXDATA unchanged and sets tx_drop.
- **RXDATA (reg3, read-only):** the last received frame, zero-extended.

Bus handshake:
- A wrce/rdce "episode" is the span during which the strobe is nonzero.
- Each episode gets exactly one ack pulse. A flag set at the ack is cleared when the strobe returns to 0.
- The register update happens on the same edge that raises `ip2bus_wrack`.
- A nonzero wrce that is not one-hot is acked and updates nothing.
- Reads have no side effects. `rdce` may sit at 4'b0001 indefinitely, and that produces only one rdack.

Engine FSM (IDLE → LEAD → SHIFT → TRAIL → IDLE):
- On start, latch cpol, cpha, clkdiv and the frame. Later CTRL writes do not affect a transfer in progress.
- Half-period H = clkdiv+1 cycles, counted by an internal down-counter.
- **IDLE:** ss_n=1, sclk=CTRL.cpol.
- **LEAD:**
  - ss_n=0 for H cycles.
  - If cpha=0, mosi = frame MSB is driven on entry.
- **SHIFT:**
  - 2·DATA_WIDTH sclk toggles, one every H cycles.
  - cpha=0: sample miso on leading (odd) edges, shift mosi on trailing edges.
  - cpha=1: shift mosi on leading edges, sample miso on trailing edges.
- **TRAIL:** sclk is back at cpol and ss_n=0 for H cycles, then IDLE with ss_n=1.
- **On the IDLE-return edge:**
  - busy clears and RXDATA is loaded.
  - If rx_valid was already 1, overrun is set.
  - rx_valid is set. A simultaneous W1C of rx_valid loses: rx_valid ends at 1.
- busy=1 for the whole of LEAD, SHIFT and TRAIL.

## Timing
- **Reset values:**
  - CTRL = {clkdiv=CLKDIV_RESET, others 0}; STATUS = 0; TXDATA = 0; RXDATA = 0.
  - Both acks 0, spi_sclk 0, spi_ss_n 1, spi_mosi 0, irq 0.
- **Reset mid-transfer:** aborts at the next edge. Outputs take their reset values, and no RXDATA or rx_valid update occurs.
- **Ack latency:** the ack is registered and rises on the first edge at which the strobe is sampled nonzero. It lasts exactly one cycle.
- **Transfer start:**
  - busy=1 and ss_n=0 from the cycle after wrack.
  - busy is high for exactly (2·DATA_WIDTH+2)·H cycles.
- **Read data:** `ip2bus_data` is registered-state combinational, valid whenever rdack is high.

## Test plan
- **Reset defaults:** assert reset 3 cycles mid-transfer → ss_n=1, sclk=0, ip2bus_data=128'h0 except CTRL=32'h0000_0400, no acks.
- **Mode 0 loopback:** CTRL=32'h0000_0001 (clkdiv 0, H=1), write TXDATA 8'hA5, tie miso=mosi → busy high 18 cycles, 8 rising sclk edges, RXDATA=8'hA5, rx_valid=1.
- **Mode 3 pattern:** CTRL=32'h0000_0307 (H=4), miso pattern 8'h3C supplied on leading edges → sclk idles high, busy 72 cycles, RXDATA=8'h3C.
- **Write while busy:** TXDATA 8'h11 then 8'h22 during the transfer → second write acked, TXDATA stays 8'h11, tx_drop=1; W1C 32'h8 clears it.
- **Overrun and irq:** two transfers without clearing, ie=1 → irq high after the first, overrun=1 after the second; writing STATUS 32'h6 clears both and drops irq.
- **Handshake:** hold rdce=4'b0001 for 10 cycles → one rdack; wrce=4'b0110 → one wrack, no register changes.
